// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types and widths for the
// initiator and the register-bank slaves.
package axi4_lite_pkg;

  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator with a
// per-transaction timeout that turns a hung slave into SLVERR.
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int addr_width     = 7,
  parameter int timeout_cycles = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [addr_width-1:0] cmd_addr,
  input  logic [AXI_DATA_W-1:0] cmd_wdata,
  input  logic [AXI_STRB_W-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [AXI_DATA_W-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic [addr_width-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [AXI_DATA_W-1:0] m_axi_wdata,
  output logic [AXI_STRB_W-1:0] m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [addr_width-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [AXI_DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESPOND
  } state_e;

  localparam bit TO_EN = timeout_cycles > 0;
  localparam int CW =
    TO_EN ? $clog2(timeout_cycles + 1) : 1;
  localparam logic [CW-1:0] TO_LAST =
    CW'(TO_EN ? timeout_cycles - 1 : 0);

  state_e                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  busy_q, busy_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [AXI_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  axi_resp_t             rsp_resp_q, rsp_resp_d;
  logic                  rsp_to_q, rsp_to_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [AXI_DATA_W-1:0] wdata_q, wdata_d;
  logic [AXI_STRB_W-1:0] wstrb_q, wstrb_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  abort;

  logic accept, on_bus, to_fire;
  logic aw_ok, w_ok;

  assign accept = cmd_valid & cmd_ready_q;
  assign on_bus = state_q inside
    {WR_REQ, WR_RESP, RD_REQ, RD_DATA};
  assign to_fire = TO_EN && on_bus
    && (cnt_q == TO_LAST);
  assign aw_ok = aw_done_q
    | (awvalid_q & m_axi_awready);
  assign w_ok = w_done_q
    | (wvalid_q & m_axi_wready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= OKAY;
      rsp_to_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_to_q    <= rsp_to_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      cnt_q       <= cnt_d;
    end
  end

  // Completing handshakes are checked first so
  // they win over a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    unique case (state_q)
      IDLE:
        if (accept)
          state_d = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:
        if (aw_ok && w_ok) state_d = WR_RESP;
        else if (to_fire) abort = 1'b1;
      WR_RESP:
        if (m_axi_bvalid) state_d = RESPOND;
        else if (to_fire) abort = 1'b1;
      RD_REQ:
        if (m_axi_arready) state_d = RD_DATA;
        else if (to_fire) abort = 1'b1;
      RD_DATA:
        if (m_axi_rvalid) state_d = RESPOND;
        else if (to_fire) abort = 1'b1;
      RESPOND:
        if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = RESPOND;
  end

  always_comb begin
    cmd_ready_d = state_d == IDLE;
    busy_d      = state_d != IDLE;
    awvalid_d   = (state_d == WR_REQ)
      && ((state_q == IDLE)
      || (awvalid_q && !m_axi_awready));
    wvalid_d    = (state_d == WR_REQ)
      && ((state_q == IDLE)
      || (wvalid_q && !m_axi_wready));
    aw_done_d   = (state_q == WR_REQ) && aw_ok;
    w_done_d    = (state_q == WR_REQ) && w_ok;
    bready_d    = state_d == WR_RESP;
    arvalid_d   = state_d == RD_REQ;
    rready_d    = state_d == RD_DATA;
    rsp_valid_d = state_d == RESPOND;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_to_d    = rsp_to_q;
    addr_d      = accept ? cmd_addr : addr_q;
    wdata_d     = accept ? cmd_wdata : wdata_q;
    wstrb_d     = accept ? cmd_wstrb : wstrb_q;
    cnt_d       = cnt_q;
    if (accept) cnt_d = '0;
    else if (on_bus) cnt_d = cnt_q + 1'b1;
    if (state_q != RESPOND && state_d == RESPOND) begin
      if (abort) begin
        rsp_rdata_d = '0;
        rsp_resp_d  = SLVERR;
        rsp_to_d    = 1'b1;
      end else if (state_q == WR_RESP) begin
        rsp_rdata_d = '0;
        rsp_resp_d  = axi_resp_t'(m_axi_bresp);
        rsp_to_d    = 1'b0;
      end else begin
        rsp_rdata_d = m_axi_rdata;
        rsp_resp_d  = axi_resp_t'(m_axi_rresp);
        rsp_to_d    = 1'b0;
      end
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign busy          = busy_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_to_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: delay-configurable slave,
// register-file reference model, directed and random steps.
module tb_axi4_lite_master;

  localparam int AW = 7;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0]   cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;
  logic          busy;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]    m_axi_awprot, m_axi_arprot;
  logic          m_axi_awvalid, m_axi_awready;
  logic [31:0]   m_axi_wdata, m_axi_rdata;
  logic [3:0]    m_axi_wstrb;
  logic          m_axi_wvalid, m_axi_wready;
  logic [1:0]    m_axi_bresp, m_axi_rresp;
  logic          m_axi_bvalid, m_axi_bready;
  logic          m_axi_arvalid, m_axi_arready;
  logic          m_axi_rvalid, m_axi_rready;

  axi4_lite_master #(
    .addr_width(AW),
    .timeout_cycles(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  int n_assert = 0;
  int n_fail = 0;

  int aw_dly = 0, w_dly = 0, b_dly = 0;
  int ar_dly = 0, r_dly = 0;
  bit ar_never = 1'b0;
  logic [1:0] bresp_cfg = 2'b00;
  logic [1:0] rresp_cfg = 2'b00;

  logic [31:0] smem [32] = '{default: 32'h0};
  logic [31:0] mmem [32] = '{default: 32'h0};

  int cyc = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  int b_cnt = 0, r_cnt = 0;
  bit aw_have = 0, w_have = 0, b_pend = 0, r_pend = 0;
  logic [AW-1:0] aw_a = '0, ar_a = '0;
  logic [31:0] w_d = '0;
  logic [3:0] w_s = '0;
  int wr_total = 0;
  int aw_hs_cyc = 0, w_hs_cyc = 0, ar_last_cyc = 0;
  int aw_hi_tot = 0, w_hi_tot = 0;

  function automatic logic [31:0] merge(
    input logic [31:0] o, d, input logic [3:0] s);
    merge = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) merge[8*b +: 8] = d[8*b +: 8];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (m_axi_awvalid) aw_hi_tot <= aw_hi_tot + 1;
    if (m_axi_wvalid) w_hi_tot <= w_hi_tot + 1;
    if (m_axi_arvalid) ar_last_cyc <= cyc;
  end

  // Slave: each ready rises once its valid has been
  // seen for the configured number of cycles.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_axi_awready <= 1'b0;
      m_axi_wready  <= 1'b0;
      m_axi_arready <= 1'b0;
      m_axi_bvalid  <= 1'b0;
      m_axi_rvalid  <= 1'b0;
      m_axi_bresp   <= 2'b00;
      m_axi_rresp   <= 2'b00;
      m_axi_rdata   <= 32'h0;
      aw_have <= 0; w_have <= 0;
      b_pend <= 0; r_pend <= 0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
    end else begin
      if (m_axi_awvalid && m_axi_awready) begin
        aw_hs_cyc <= cyc;
        aw_cnt <= 0;
        m_axi_awready <= aw_dly == 0;
      end else if (m_axi_awvalid) begin
        aw_cnt <= aw_cnt + 1;
        m_axi_awready <= aw_cnt + 1 >= aw_dly;
      end else begin
        aw_cnt <= 0;
        m_axi_awready <= aw_dly == 0;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_hs_cyc <= cyc;
        w_cnt <= 0;
        m_axi_wready <= w_dly == 0;
      end else if (m_axi_wvalid) begin
        w_cnt <= w_cnt + 1;
        m_axi_wready <= w_cnt + 1 >= w_dly;
      end else begin
        w_cnt <= 0;
        m_axi_wready <= w_dly == 0;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        ar_cnt <= 0;
        m_axi_arready <= !ar_never && ar_dly == 0;
      end else if (m_axi_arvalid) begin
        ar_cnt <= ar_cnt + 1;
        m_axi_arready <= !ar_never
          && ar_cnt + 1 >= ar_dly;
      end else begin
        ar_cnt <= 0;
        m_axi_arready <= !ar_never && ar_dly == 0;
      end
      if (m_axi_bvalid && m_axi_bready)
        m_axi_bvalid <= 1'b0;
      if ((aw_have || (m_axi_awvalid && m_axi_awready))
        && (w_have || (m_axi_wvalid && m_axi_wready)))
      begin
        smem[aw_have ? aw_a[6:2] : m_axi_awaddr[6:2]]
          <= merge(
            smem[aw_have ? aw_a[6:2]
              : m_axi_awaddr[6:2]],
            w_have ? w_d : m_axi_wdata,
            w_have ? w_s : m_axi_wstrb);
        wr_total <= wr_total + 1;
        aw_have <= 0;
        w_have <= 0;
        if (b_dly == 0) begin
          m_axi_bvalid <= 1'b1;
          m_axi_bresp <= bresp_cfg;
        end else begin
          b_pend <= 1;
          b_cnt <= b_dly;
        end
      end else begin
        if (m_axi_awvalid && m_axi_awready) begin
          aw_have <= 1;
          aw_a <= m_axi_awaddr;
        end
        if (m_axi_wvalid && m_axi_wready) begin
          w_have <= 1;
          w_d <= m_axi_wdata;
          w_s <= m_axi_wstrb;
        end
        if (b_pend) begin
          if (b_cnt == 1) begin
            m_axi_bvalid <= 1'b1;
            m_axi_bresp <= bresp_cfg;
            b_pend <= 0;
          end else b_cnt <= b_cnt - 1;
        end
      end
      if (m_axi_rvalid && m_axi_rready)
        m_axi_rvalid <= 1'b0;
      if (m_axi_arvalid && m_axi_arready) begin
        if (r_dly == 0) begin
          m_axi_rvalid <= 1'b1;
          m_axi_rdata <= smem[m_axi_araddr[6:2]];
          m_axi_rresp <= rresp_cfg;
        end else begin
          r_pend <= 1;
          r_cnt <= r_dly;
          ar_a <= m_axi_araddr;
        end
      end else if (r_pend) begin
        if (r_cnt == 1) begin
          m_axi_rvalid <= 1'b1;
          m_axi_rdata <= smem[ar_a[6:2]];
          m_axi_rresp <= rresp_cfg;
          r_pend <= 0;
        end else r_cnt <= r_cnt - 1;
      end
    end
  end

  task automatic chk(input string tag,
    input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
        tag, obs, exp);
    end
  endtask

  int acc_cyc = 0;
  int aw0 = 0, w0 = 0, wr0 = 0;

  task automatic model_wr(input logic [AW-1:0] a,
    input logic [31:0] d, input logic [3:0] s);
    mmem[a[6:2]] = merge(mmem[a[6:2]], d, s);
  endtask

  // Tasks start and end at a falling edge.
  task automatic issue(input bit w,
    input logic [AW-1:0] a, input logic [31:0] d,
    input logic [3:0] s);
    int n;
    cmd_write = w;
    cmd_addr = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_budget", n, 0);
    acc_cyc = cyc;
    aw0 = aw_hi_tot;
    w0 = w_hi_tot;
    wr0 = wr_total;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic txn(input bit w,
    input logic [AW-1:0] a, input logic [31:0] d,
    input logic [3:0] s, output logic [31:0] rd,
    output logic [1:0] rp, output logic to,
    output int lat);
    issue(w, a, d, s);
    wait_rsp(lat);
    rd = rsp_rdata;
    rp = rsp_resp;
    to = rsp_timeout;
    finish_rsp();
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0] rp;
    logic to;
    int lat, hs_cyc, n, idx, exp_lat;
    bit w;
    logic [31:0] d;
    logic [3:0] s;
    logic [AW-1:0] a;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_awvalid", m_axi_awvalid, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_rst", cmd_ready, 1);

    model_wr(7'h04, 32'hDEADBEEF, 4'hF);
    issue(1, 7'h04, 32'hDEADBEEF, 4'hF);
    chk("wr0_awvalid_c1", m_axi_awvalid, 1);
    chk("wr0_wvalid_c1", m_axi_wvalid, 1);
    chk("wr0_prot", {m_axi_awprot, m_axi_arprot}, 0);
    wait_rsp(lat);
    chk("wr0_aw_cycle", aw_hs_cyc - acc_cyc, 1);
    chk("wr0_w_cycle", w_hs_cyc - acc_cyc, 1);
    chk("wr0_latency", lat, 3);
    chk("wr0_resp", rsp_resp, 2'b00);
    chk("wr0_timeout", rsp_timeout, 0);
    finish_rsp();
    txn(0, 7'h04, 0, 0, rd, rp, to, lat);
    chk("rd0_data", rd, mmem[1]);
    chk("rd0_latency", lat, 3);

    aw_dly = 3;
    model_wr(7'h14, 32'h0BADF00D, 4'hF);
    txn(1, 7'h14, 32'h0BADF00D, 4'hF,
      rd, rp, to, lat);
    chk("skew_w_cycle", w_hs_cyc - acc_cyc, 1);
    chk("skew_aw_cycle", aw_hs_cyc - acc_cyc, 4);
    chk("skew_w_high", w_hi_tot - w0, 1);
    chk("skew_aw_high", aw_hi_tot - aw0, 4);
    chk("skew_writes", wr_total - wr0, 1);
    chk("skew_resp", rp, 2'b00);
    aw_dly = 0;

    model_wr(7'h08, 32'h12345678, 4'hF);
    txn(1, 7'h08, 32'h12345678, 4'hF,
      rd, rp, to, lat);
    rresp_cfg = 2'b11;
    txn(0, 7'h08, 0, 0, rd, rp, to, lat);
    chk("rd8_data", rd, 32'h12345678);
    chk("rd8_resp", rp, 2'b11);
    chk("rd8_timeout", to, 0);
    rresp_cfg = 2'b00;

    ar_never = 1'b1;
    issue(0, 7'h0C, 0, 0);
    wait_rsp(lat);
    chk("to_latency", lat, 17);
    chk("to_ar_last", ar_last_cyc - acc_cyc, 16);
    chk("to_arvalid", m_axi_arvalid, 0);
    chk("to_rready", m_axi_rready, 0);
    chk("to_resp", rsp_resp, 2'b10);
    chk("to_flag", rsp_timeout, 1);
    chk("to_rdata", rsp_rdata, 0);
    finish_rsp();
    ar_never = 1'b0;

    model_wr(7'h0C, 32'hA5A55A5A, 4'h3);
    issue(1, 7'h0C, 32'hA5A55A5A, 4'h3);
    wait_rsp(lat);
    cmd_write = 1'b0;
    cmd_addr = 7'h0C;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_resp", rsp_resp, 2'b00);
      chk("hold_rdata", rsp_rdata, 0);
      chk("hold_timeout", rsp_timeout, 0);
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    hs_cyc = cyc;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("hold_accept_ready", cmd_ready, 1);
    acc_cyc = cyc;
    chk("hold_accept_cycle", acc_cyc - hs_cyc, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp(lat);
    chk("hold_rd_latency", lat, 3);
    chk("hold_rd_data", rsp_rdata, mmem[3]);
    finish_rsp();

    b_dly = 5;
    model_wr(7'h10, 32'hCAFEF00D, 4'hF);
    issue(1, 7'h10, 32'hCAFEF00D, 4'hF);
    n = 0;
    while (!m_axi_bready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_in_wr_resp", m_axi_bready, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cmd_ready", cmd_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_bready", m_axi_bready, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_valids", {m_axi_awvalid,
      m_axi_wvalid, m_axi_arvalid, m_axi_rready}, 0);
    chk("arst_addr", m_axi_awaddr, 0);
    chk("arst_wdata", m_axi_wdata, 0);
    chk("arst_rsp_rdata", rsp_rdata, 0);
    chk("arst_rsp_resp", rsp_resp, 0);
    b_dly = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_release_ready", cmd_ready, 1);
    txn(0, 7'h10, 0, 0, rd, rp, to, lat);
    chk("arst_rd_data", rd, mmem[4]);
    chk("arst_rd_latency", lat, 3);
    chk("arst_rd_resp", rp, 2'b00);

    for (int t = 0; t < 40; t++) begin
      aw_dly = $urandom_range(0, 3);
      w_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3);
      r_dly = $urandom_range(0, 3);
      bresp_cfg = 2'($urandom_range(0, 3));
      rresp_cfg = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      idx = $urandom_range(0, 31);
      a = {5'(idx), 2'b00};
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      @(negedge clk);
      if (w) begin
        model_wr(a, d, s);
        exp_lat = (aw_dly > w_dly ? aw_dly : w_dly)
          + 3 + b_dly;
      end else begin
        exp_lat = ar_dly + 3 + r_dly;
      end
      txn(w, a, d, s, rd, rp, to, lat);
      chk("rnd_latency", lat, exp_lat);
      chk("rnd_rdata", rd, w ? 32'h0 : mmem[idx]);
      chk("rnd_resp", rp, w ? bresp_cfg : rresp_cfg);
      chk("rnd_timeout", to, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
      n_assert, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi4_lite_master.md
# axi4_lite_master

Single-outstanding AXI4-Lite initiator that converts a simple command/response stream into AXI4-Lite read and write transactions. It is the initiator counterpart of the team's register-bank slaves. Typical uses are PL-side configuration sequencers and interrupt-service engines that program other blocks without going through the PS. A per-transaction timeout converts a hung slave into an error response instead of a deadlock.

## Interface
- `addr_width`, default 7: width of `cmd_addr` and `m_axi_awaddr`/`m_axi_araddr`.
- `timeout_cycles`, default 1024: maximum number of cycles a transaction may spend on the bus; 0 disables the timeout.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- `clk` in, 1: sole clock; all logic is on the rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `cmd_valid` in, 1 / `cmd_ready` out, 1: command handshake.
- `cmd_write` in, 1: 1 = write, 0 = read.
- `cmd_addr` in, addr_width / `cmd_wdata` in, 32 / `cmd_wstrb` in, 4: command payload.
- `rsp_valid` out, 1 / `rsp_ready` in, 1: response handshake.
- `rsp_rdata` out, 32: read data; 0 for writes and timeouts.
- `rsp_resp` out, 2: BRESP/RRESP, or SLVERR on timeout.
- `rsp_timeout` out, 1: the transaction was aborted by the timeout.
- `busy` out, 1: high whenever the FSM is not IDLE.
- `m_axi_aw{addr,prot,valid,ready}`, `m_axi_w{data,strb,valid,ready}`, `m_axi_b{resp,valid,ready}`, `m_axi_ar{addr,prot,valid,ready}`, `m_axi_r{data,resp,valid,ready}`: standard AXI4-Lite master ports, 32-bit data, addr_width addresses. `*prot` is tied to 3'b000.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESPOND.
- IDLE
  - `cmd_ready` = 1.
  - On `cmd_valid`, latch addr, wdata, wstrb and write.
  - Go to WR_REQ if write, otherwise RD_REQ.
- WR_REQ
  - Assert `awvalid` and `wvalid` together.
  - Each one drops independently in the cycle after its own handshake.
  - Go to WR_RESP once both handshakes have completed, in either order or in the same cycle.
- WR_RESP
  - `bready` = 1.
  - On `bvalid`, capture `bresp` and go to RESPOND.
- RD_REQ
  - `arvalid` = 1 until `arready`, then go to RD_DATA.
- RD_DATA
  - `rready` = 1.
  - On `rvalid`, capture `rdata` and `rresp` and go to RESPOND.
- RESPOND
  - `rsp_valid` = 1 with the captured fields.
  - On `rsp_ready`, go to IDLE.
- Timeout
  - Counter is cleared on command accept and increments every cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
  - When it reaches `timeout_cycles` (if nonzero), all AXI valids and readies drop in the next cycle.
  - The FSM then enters RESPOND with `rsp_resp` = 2'b10, `rsp_timeout` = 1, `rsp_rdata` = 0.
  - This is an abort: the slave must be reset before it is reused.
- Once asserted, valids are never withdrawn before their handshake, except by a timeout or by reset.
- Payload outputs stay stable while their valid is high.

## Timing
- All outputs are registered.
- Reset values:
  - All `m_axi_*valid` and `*ready` = 0; `cmd_ready` = 0 during reset and 1 in the first cycle after release.
  - `rsp_valid` = 0, `busy` = 0, data/resp/addr outputs = 0, FSM in IDLE.
- Write latency with a zero-wait slave:
  - cmd accepted at cycle 0.
  - `awvalid`/`wvalid` high at cycle 1 and handshaken there.
  - `bready` high at cycle 2; `bvalid` at cycle 2.
  - `rsp_valid` at cycle 3.
- Read latency with a zero-wait slave:
  - `arvalid` at cycle 1.
  - `rready` at cycle 2; `rvalid` at cycle 2.
  - `rsp_valid` at cycle 3.
- Next command can be accepted in the cycle after the `rsp_ready` handshake; there is one outstanding transaction maximum.
- A timeout firing in the same cycle as the completing handshake loses: the real response wins.
- Reset mid-transaction returns to the reset values immediately (asynchronous).

## Structure
- Shared package `axi4_lite_pkg`:
  - `axi_resp_t` enum: OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11.
  - `AXI_DATA_W` = 32, `AXI_STRB_W` = 4.
- FSM state enum is local to the module.
- Single module with no sub-module; the timeout counter is `$clog2(timeout_cycles+1)` bits wide, minimum 1.

## Test plan
- Write addr 0x04, data 0xDEADBEEF, strb 0xF to a zero-wait slave model:
  - aw/w at cycle 1, `rsp_valid` at cycle 3, `rsp_resp` = 0, register reads back 0xDEADBEEF.
- Slave asserts `wready` 3 cycles before `awready`:
  - `wvalid` drops after its handshake while `awvalid` is held.
  - Exactly one write; OKAY response.
- Read addr 0x08 with the slave returning 0x12345678, `rresp` = 2'b11:
  - `rsp_rdata` = 0x12345678, `rsp_resp` = 2'b11, `rsp_timeout` = 0.
- `timeout_cycles` = 16, slave never asserts `arready`:
  - `arvalid` drops at cycle 17.
  - `rsp_valid` with `rsp_resp` = 2'b10, `rsp_timeout` = 1, `rdata` = 0.
- `rsp_ready` held low for 5 cycles:
  - Response fields stable, `cmd_ready` = 0 throughout.
  - A command presented meanwhile is accepted only after the handshake.
- `rst_n` asserted while in WR_RESP:
  - All outputs take reset values asynchronously.
  - A subsequent read completes normally.
